// File: rtl/baud_pkg.sv
// Shared definitions for the UART baud-rate generator: legality limits,
// configuration handshake states and the phase-increment calculation.
package baud_pkg;

    localparam int unsigned OVERSAMPLE_MIN = 4;
    localparam int unsigned OVERSAMPLE_MAX = 64;
    localparam int unsigned ACC_W_MIN      = 16;
    localparam int unsigned ACC_W_MAX      = 32;

    typedef enum logic {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_t;

    function automatic bit is_pow2(input longint unsigned v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

    function automatic bit params_legal(input int unsigned os, input int unsigned accw);
        return is_pow2(64'(os)) &&
               (os >= OVERSAMPLE_MIN) && (os <= OVERSAMPLE_MAX) &&
               (accw >= ACC_W_MIN) && (accw <= ACC_W_MAX);
    endfunction

    // round(baud * os * 2^accw / sysclk), masked to accw bits.
    function automatic logic [63:0] calc_inc(
        input longint unsigned sysclk,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned accw
    );
        logic [63:0] num;
        logic [63:0] quo;
        logic [63:0] mask;
        num  = (baud * os) << accw;
        quo  = (num + (sysclk >> 1)) / sysclk;
        mask = (accw >= 64) ? '1 : ((64'd1 << accw) - 64'd1);
        return quo & mask;
    endfunction

endpackage

// File: rtl/baud_nco.sv
// Fractional phase accumulator; carry_q is the registered overflow and
// carry is the overflow about to be registered on the coming edge.
module baud_nco
    import baud_pkg::*;
#(
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [ACC_W-1:0] inc,
    output logic             carry,
    output logic             carry_q
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc} + {1'b0, inc};
        carry = en && !sync && sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (sync) begin
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (en) begin
            acc     <= sum[ACC_W-1:0];
            carry_q <= sum[ACC_W];
        end else begin
            carry_q <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud-rate generator: NCO-driven rx_tick at OVERSAMPLE x baud,
// tx_tick at baud, with increment updates deferred to bit boundaries.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned SYSCLK_HZ    = 100_000_000,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned ACC_W        = 24,
    parameter int unsigned DEFAULT_BAUD = 9600
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sync,
    input  logic                          cfg_valid,
    input  logic [ACC_W-1:0]              cfg_inc,
    output logic                          cfg_ready,
    output logic                          rx_tick,
    output logic                          tx_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] rx_phase,
    output logic [ACC_W-1:0]              inc_cur
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] DIV_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [ACC_W-1:0] DEFAULT_INC =
        ACC_W'(calc_inc(64'(SYSCLK_HZ), 64'(DEFAULT_BAUD), 64'(OVERSAMPLE), 64'(ACC_W)));

    if (!params_legal(OVERSAMPLE, ACC_W)) begin : g_param_check
        $error("baud_tick_gen: OVERSAMPLE must be a power of two in 4..64 and ACC_W in 16..32");
    end

    logic             carry;
    logic [PH_W-1:0]  div;
    logic             tx_gen;
    logic [ACC_W-1:0] pend;
    cfg_state_t       cfg_state;
    cfg_state_t       cfg_state_next;
    logic             cfg_load;
    logic             cfg_apply;

    baud_nco #(
        .ACC_W(ACC_W)
    ) u_nco (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .inc     (inc_cur),
        .carry   (carry),
        .carry_q (rx_tick)
    );

    assign tx_gen = carry && (div == DIV_LAST);

    // rx_phase takes the pre-increment div so each rx_tick carries its own index.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            rx_phase <= '0;
            tx_tick  <= 1'b0;
        end else if (sync) begin
            div      <= '0;
            rx_phase <= '0;
            tx_tick  <= 1'b0;
        end else begin
            tx_tick <= tx_gen;
            if (carry) begin
                rx_phase <= div;
                div      <= (div == DIV_LAST) ? '0 : div + PH_W'(1);
            end
        end
    end

    always_comb begin
        cfg_state_next = cfg_state;
        cfg_load       = 1'b0;
        cfg_apply      = 1'b0;
        case (cfg_state)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    cfg_load       = 1'b1;
                    cfg_state_next = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (sync || !en || tx_gen) begin
                    cfg_apply      = 1'b1;
                    cfg_state_next = CFG_IDLE;
                end
            end
            default: cfg_state_next = CFG_IDLE;
        endcase
    end

    // A transfer coinciding with sync lands in pend and waits for the next apply point.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_state <= CFG_IDLE;
            pend      <= '0;
            inc_cur   <= DEFAULT_INC;
        end else begin
            cfg_state <= cfg_state_next;
            if (cfg_load) begin
                pend <= cfg_inc;
            end
            if (cfg_apply) begin
                inc_cur <= pend;
            end
        end
    end

    assign cfg_ready = (cfg_state == CFG_IDLE);

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed self-checking bench for baud_tick_gen with default parameters.
module tb_baud_tick_gen;

    localparam int unsigned ACC_W = 24;
    localparam int unsigned OS    = 16;
    localparam logic [ACC_W-1:0] INC_DEF = 24'd25770;
    localparam logic [ACC_W-1:0] INC_4   = 24'd4194304;
    localparam logic [ACC_W-1:0] INC_8   = 24'd2097152;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sync;
    logic             cfg_valid;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_ready;
    logic             rx_tick;
    logic             tx_tick;
    logic [3:0]       rx_phase;
    logic [ACC_W-1:0] inc_cur;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    baud_tick_gen #(
        .SYSCLK_HZ   (100_000_000),
        .OVERSAMPLE  (16),
        .ACC_W       (24),
        .DEFAULT_BAUD(9600)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_inc  (cfg_inc),
        .cfg_ready(cfg_ready),
        .rx_tick  (rx_tick),
        .tx_tick  (tx_tick),
        .rx_phase (rx_phase),
        .inc_cur  (inc_cur)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_sync(input logic [ACC_W-1:0] value);
        cfg_valid = 1'b1;
        cfg_inc   = value;
        step();
        cfg_valid = 1'b0;
        sync      = 1'b1;
        step();
        sync      = 1'b0;
    endtask

    task automatic test_reset();
        int first_rx, second_rx, n_rx, rx_at_tx, tx1, tx3, n_tx, ph_err, tx_err;
        logic [3:0] exp_ph;
        first_rx = 0; second_rx = 0; n_rx = 0; rx_at_tx = 0;
        tx1 = 0; tx3 = 0; n_tx = 0; ph_err = 0; tx_err = 0;
        rst = 1'b1; en = 1'b1; sync = 1'b0; cfg_valid = 1'b0; cfg_inc = '0;
        repeat (3) step();
        checks++; if (inc_cur !== INC_DEF) begin errors++; $display("FAIL reset_inc_cur: got %0d expected %0d", inc_cur, INC_DEF); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        checks++; if ({rx_tick, tx_tick} !== 2'b00) begin errors++; $display("FAIL reset_ticks: got %b expected 00", {rx_tick, tx_tick}); end
        checks++; if (rx_phase !== 4'd0) begin errors++; $display("FAIL reset_rx_phase: got %0d expected 0", rx_phase); end
        rst = 1'b0;
        for (int c = 1; c <= 31300; c++) begin
            step();
            if (rx_tick === 1'b1) begin
                exp_ph = 4'(n_rx % OS);
                if (rx_phase !== exp_ph) ph_err++;
                n_rx++;
                if (n_rx == 1) first_rx = c;
                else if (n_rx == 2) second_rx = c;
            end
            if (tx_tick === 1'b1) begin
                if (!(rx_tick === 1'b1 && rx_phase === 4'd15)) tx_err++;
                n_tx++;
                if (n_tx == 1) begin tx1 = c; rx_at_tx = n_rx; end
                if (n_tx == 3) tx3 = c;
            end
        end
        checks++; if (first_rx != 652) begin errors++; $display("FAIL default_first_rx: got %0d expected 652", first_rx); end
        checks++; if (second_rx - first_rx != 651) begin errors++; $display("FAIL default_rx_period: got %0d expected 651", second_rx - first_rx); end
        checks++; if (rx_at_tx != 16) begin errors++; $display("FAIL default_rx_per_tx: got %0d expected 16", rx_at_tx); end
        checks++; if (tx1 != 10417) begin errors++; $display("FAIL default_first_tx: got %0d expected 10417", tx1); end
        checks++; if (tx3 - tx1 != 20833) begin errors++; $display("FAIL default_two_bits: got %0d expected 20833", tx3 - tx1); end
        checks++; if (n_tx != 3) begin errors++; $display("FAIL default_tx_count: got %0d expected 3", n_tx); end
        checks++; if (ph_err != 0) begin errors++; $display("FAIL default_rx_phase_seq: got %0d bad ticks expected 0", ph_err); end
        checks++; if (tx_err != 0) begin errors++; $display("FAIL default_tx_coincide: got %0d bad ticks expected 0", tx_err); end
    endtask

    task automatic test_exact_rate();
        int rx_err, tx_err, ph_err;
        logic exp_rx, exp_tx;
        logic [3:0] exp_ph;
        rx_err = 0; tx_err = 0; ph_err = 0;
        cfg_valid = 1'b1; cfg_inc = INC_4;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL exact_cfg_ready_drop: got %b expected 0", cfg_ready); end
        checks++; if (inc_cur !== INC_DEF) begin errors++; $display("FAIL exact_inc_before_sync: got %0d expected %0d", inc_cur, INC_DEF); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++; if (inc_cur !== INC_4) begin errors++; $display("FAIL exact_inc_applied: got %0d expected %0d", inc_cur, INC_4); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL exact_cfg_ready_back: got %b expected 1", cfg_ready); end
        for (int c = 1; c <= 128; c++) begin
            step();
            exp_rx = (c % 4 == 0);
            exp_tx = (c % 64 == 0);
            if (rx_tick !== exp_rx) rx_err++;
            if (tx_tick !== exp_tx) tx_err++;
            if (exp_rx) begin
                exp_ph = 4'((c / 4 - 1) % 16);
                if (rx_phase !== exp_ph) ph_err++;
            end
        end
        checks++; if (rx_err != 0) begin errors++; $display("FAIL exact_rx_every_4: got %0d bad cycles expected 0", rx_err); end
        checks++; if (tx_err != 0) begin errors++; $display("FAIL exact_tx_every_64: got %0d bad cycles expected 0", tx_err); end
        checks++; if (ph_err != 0) begin errors++; $display("FAIL exact_rx_phase: got %0d bad ticks expected 0", ph_err); end
    endtask

    task automatic test_cfg_timing();
        int rx_err;
        logic exp_rx;
        rx_err = 0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        repeat (22) step();
        cfg_valid = 1'b1; cfg_inc = INC_8;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_drop: got %b expected 0", cfg_ready); end
        checks++; if (inc_cur !== INC_4) begin errors++; $display("FAIL cfg_not_yet_applied: got %0d expected %0d", inc_cur, INC_4); end
        for (int c = 24; c <= 96; c++) begin
            step();
            exp_rx = (c <= 64) ? (c % 4 == 0) : ((c - 64) % 8 == 0);
            if (rx_tick !== exp_rx) rx_err++;
            if (c == 63) begin
                checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_before_apply: got %b expected 0", cfg_ready); end
            end
            if (c == 64) begin
                checks++; if (tx_tick !== 1'b1) begin errors++; $display("FAIL cfg_apply_tx: got %b expected 1", tx_tick); end
                checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_after_apply: got %b expected 1", cfg_ready); end
                checks++; if (inc_cur !== INC_8) begin errors++; $display("FAIL cfg_inc_applied: got %0d expected %0d", inc_cur, INC_8); end
            end
        end
        checks++; if (rx_err != 0) begin errors++; $display("FAIL cfg_rate_switch: got %0d bad cycles expected 0", rx_err); end
    endtask

    task automatic test_enable_park();
        int hold_err, lat, parked_ticks;
        logic [3:0] ph;
        hold_err = 0; lat = 0; ph = '0; parked_ticks = 0;
        load_and_sync(INC_4);
        repeat (42) step();
        checks++; if (rx_phase !== 4'd9) begin errors++; $display("FAIL en_phase_before: got %0d expected 9", rx_phase); end
        en = 1'b0;
        repeat (37) begin
            step();
            if (rx_tick !== 1'b0 || tx_tick !== 1'b0 || rx_phase !== 4'd9) hold_err++;
        end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL en_hold: got %0d bad cycles expected 0", hold_err); end
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (rx_tick === 1'b1 && lat == 0) begin lat = i; ph = rx_phase; end
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL en_resume_latency: got %0d expected 2", lat); end
        checks++; if (ph !== 4'd10) begin errors++; $display("FAIL en_resume_phase: got %0d expected 10", ph); end
        load_and_sync('0);
        checks++; if (inc_cur !== '0) begin errors++; $display("FAIL park_inc: got %0d expected 0", inc_cur); end
        repeat (10000) begin
            step();
            if (rx_tick !== 1'b0 || tx_tick !== 1'b0) parked_ticks++;
        end
        checks++; if (parked_ticks != 0) begin errors++; $display("FAIL park_no_ticks: got %0d expected 0", parked_ticks); end
    endtask

    task automatic test_sync_mid_bit();
        int first_rx, first_tx;
        first_rx = 0; first_tx = 0;
        load_and_sync(INC_4);
        repeat (42) step();
        checks++; if (rx_phase !== 4'd9) begin errors++; $display("FAIL sync_phase_before: got %0d expected 9", rx_phase); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++; if (rx_phase !== 4'd0) begin errors++; $display("FAIL sync_phase_cleared: got %0d expected 0", rx_phase); end
        checks++; if ({rx_tick, tx_tick} !== 2'b00) begin errors++; $display("FAIL sync_ticks_cleared: got %b expected 00", {rx_tick, tx_tick}); end
        for (int s = 1; s <= 70; s++) begin
            step();
            if (rx_tick === 1'b1 && first_rx == 0) first_rx = s;
            if (tx_tick === 1'b1 && first_tx == 0) first_tx = s;
        end
        checks++; if (first_rx != 4) begin errors++; $display("FAIL sync_first_rx: got %0d expected 4", first_rx); end
        checks++; if (first_tx != 64) begin errors++; $display("FAIL sync_first_tx: got %0d expected 64", first_tx); end
    endtask

    task automatic test_sync_cfg_collision();
        cfg_valid = 1'b1; cfg_inc = INC_8; sync = 1'b1;
        step();
        cfg_valid = 1'b0; sync = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL collide_captured: got %b expected 0", cfg_ready); end
        checks++; if (inc_cur !== INC_4) begin errors++; $display("FAIL collide_not_applied: got %0d expected %0d", inc_cur, INC_4); end
        for (int s = 1; s <= 64; s++) begin
            step();
            if (s == 63) begin
                checks++; if (inc_cur !== INC_4) begin errors++; $display("FAIL collide_wait: got %0d expected %0d", inc_cur, INC_4); end
            end
            if (s == 64) begin
                checks++; if (tx_tick !== 1'b1) begin errors++; $display("FAIL collide_tx: got %b expected 1", tx_tick); end
                checks++; if (inc_cur !== INC_8) begin errors++; $display("FAIL collide_applied: got %0d expected %0d", inc_cur, INC_8); end
            end
        end
    endtask

    task automatic test_reset_mid_cfg();
        cfg_valid = 1'b1; cfg_inc = 24'd12345;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstcfg_pending: got %b expected 0", cfg_ready); end
        rst = 1'b1;
        repeat (2) step();
        checks++; if (inc_cur !== INC_DEF) begin errors++; $display("FAIL rstcfg_inc: got %0d expected %0d", inc_cur, INC_DEF); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstcfg_ready: got %b expected 1", cfg_ready); end
        checks++; if ({rx_tick, tx_tick, rx_phase} !== 6'd0) begin errors++; $display("FAIL rstcfg_outputs: got %b expected 000000", {rx_tick, tx_tick, rx_phase}); end
        rst = 1'b0; en = 1'b0;
        repeat (3) step();
        checks++; if (inc_cur !== INC_DEF) begin errors++; $display("FAIL rstcfg_discarded: got %0d expected %0d", inc_cur, INC_DEF); end
        // With en low the pending value applies on the edge after the transfer.
        cfg_valid = 1'b1; cfg_inc = 24'd777;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0 || inc_cur !== INC_DEF) begin errors++; $display("FAIL en0_transfer: got ready=%b inc=%0d expected ready=0 inc=%0d", cfg_ready, inc_cur, INC_DEF); end
        step();
        checks++; if (inc_cur !== 24'd777) begin errors++; $display("FAIL en0_apply_inc: got %0d expected 777", inc_cur); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL en0_apply_ready: got %b expected 1", cfg_ready); end
    endtask

    initial begin
        test_reset();
        test_exact_rate();
        test_cfg_timing();
        test_enable_park();
        test_sync_mid_bit();
        test_sync_cfg_collision();
        test_reset_mid_cfg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised, run-time-programmable baud-rate generator for the UART TX/RX paths.
- Built on a fractional phase accumulator (NCO), so any baud rate is reachable without integer-divider rounding error.
- Emits single-cycle clock-enable pulses, not derived clocks: rx_tick at OVERSAMPLE x baud and tx_tick at baud, both in the clk domain.
- Supports glitch-free divisor updates at bit boundaries and phase re-synchronisation from the receiver's start-bit detector.

Parameters:
- SYSCLK_HZ, 100_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, rx_tick pulses per tx_tick. Must be a power of two, 4..64.
- ACC_W, 24, phase accumulator width. Range 16..32.
- DEFAULT_BAUD, 9600, baud rate in force after reset.
- DEFAULT_INC, derived, round(DEFAULT_BAUD*OVERSAMPLE*2^ACC_W / SYSCLK_HZ), computed in 64-bit arithmetic. Value is 25770 for the defaults.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous, active-high reset.
- en, in, 1, generator enable.
- sync, in, 1, single-cycle phase re-alignment request.
- cfg_valid, in, 1, new increment offered.
- cfg_inc, in, ACC_W, phase increment = round(baud*OVERSAMPLE*2^ACC_W / SYSCLK_HZ).
- cfg_ready, out, 1, generator can accept a new increment.
- rx_tick, out, 1, oversample enable pulse.
- tx_tick, out, 1, bit-rate enable pulse.
- rx_phase, out, $clog2(OVERSAMPLE), oversample index within the current bit.
- inc_cur, out, ACC_W, increment currently in use.

Behaviour:
- Reset, and priority order:
  - Reset values: acc=0, div=0, rx_tick=0, tx_tick=0, rx_phase=0, inc_cur=DEFAULT_INC, pend_valid=0, cfg_ready=1.
  - Priority each cycle: rst > sync > normal operation.
  - rst asserted mid-operation aborts any pending config, which is lost.
- Accumulator (en=1, no sync):
  - Each clk edge: {carry, acc} <= acc + inc_cur, with ACC_W+1-bit sum and natural wrap.
  - rx_tick <= carry. rx_tick is registered, high exactly one cycle per overflow, never two consecutive cycles unless inc_cur >= 2^(ACC_W-1).
- Divider:
  - On every carry: div <= (div == OVERSAMPLE-1) ? 0 : div+1.
  - tx_tick <= carry && (div == OVERSAMPLE-1), so tx_tick always coincides with an rx_tick.
  - rx_phase = div, registered, and updates in the same cycle as rx_tick.
- en=0:
  - acc and div hold.
  - rx_tick and tx_tick are 0 on the next cycle.
  - Re-asserting en resumes from the held phase.
- inc_cur = 0: no ticks ever. This is legal, a parked generator.
- Configuration handshake:
  - Transfer occurs when cfg_valid && cfg_ready. pend <= cfg_inc, pend_valid <= 1, cfg_ready <= 0.
  - Apply point is the first edge where a tx_tick is generated (div wrap), or the next edge if en=0, or a sync cycle. At that point inc_cur <= pend and pend_valid <= 0. cfg_ready returns to 1 the following cycle.
  - The addition on the apply edge uses the old inc_cur; the new value takes effect from the next addition.
  - cfg_valid while cfg_ready=0 is ignored; the source must hold cfg_valid.
- sync (en either value):
  - acc <= 0, div <= 0, rx_tick and tx_tick <= 0 that cycle.
  - Any pending increment is applied.
  - The first rx_tick after sync occurs after ceil(2^ACC_W / inc_cur) additions.
- Simultaneous sync and cfg transfer: the new cfg is captured into pend (cfg_ready drops) and is not applied at that sync. It waits for the next apply point.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Package baud_pkg:
  - Function calc_inc(sysclk, baud, os, accw), returning a 64-bit rounded value truncated to ACC_W.
  - Legality-check constants for OVERSAMPLE and ACC_W.
  - Shared with the UART TX/RX and the register-file block, which computes cfg_inc.
- One sub-module, baud_nco: accumulator plus carry register, with inputs en, sync, inc and outputs carry_q. The parent holds the divider, config holding register and handshake.

Test Plan:
- Reset: hold rst 3 cycles, release with en=1, cfg idle -> inc_cur=25770, first rx_tick within 652 cycles, rx_tick period 651 or 652 cycles, tx_tick every 16th rx_tick, long-run tx period averages 10416.5 cycles ±1 over 100 bits.
- Exact rate: load cfg_inc=2^22 (4194304), then sync -> rx_tick exactly every 4 cycles, tx_tick every 64 cycles coincident with rx_tick where rx_phase=15.
- Config timing: with inc=2^22 running, offer cfg_inc=2^21 mid-bit -> cfg_ready drops the next cycle, old 4-cycle rate persists until the next tx_tick, then an 8-cycle rate applies, and cfg_ready=1 one cycle after the apply point.
- Enable and park: with inc=2^22, deassert en for 37 cycles -> no ticks, rx_phase frozen, and the phase continues seamlessly on re-enable. Setting cfg_inc=0 -> no ticks for 10000 cycles.
- Sync mid-bit: with inc=2^22, pulse sync when rx_phase=9 -> rx_phase=0 and ticks 0 that cycle, the next rx_tick 4 cycles later, and tx_tick 64 cycles after sync.
- Reset mid-config: hold cfg pending, assert rst -> inc_cur=25770, cfg_ready=1, pending value discarded.
